// File: rtl/rr_enc_arbiter8_if.sv
// Request/grant bundle between the requester bank and the round-robin encoder arbiter.
// The master drives requests; the slave (arbiter) returns a one-hot and encoded grant.
interface rr_enc_arbiter8_if;
  logic       en;
  logic [7:0] req;
  logic       rel;
  logic       gnt_valid;
  logic [7:0] gnt_onehot;
  logic [2:0] gnt_idx;
  logic       timeout;

  modport master (
    output en, req, rel,
    input  gnt_valid, gnt_onehot, gnt_idx, timeout
  );

  modport slave (
    input  en, req, rel,
    output gnt_valid, gnt_onehot, gnt_idx, timeout
  );
endinterface

// File: rtl/rr_enc_arbiter8.sv
// Round-robin arbiter for 8 requesters; grant is presented one-hot and as a 3-bit index.
// Define ARB_TIMEOUT_EN to add a hold timer that revokes a grant after MAX_HOLD cycles.
module rr_enc_arbiter8
`ifdef ARB_TIMEOUT_EN
  #(parameter int MAX_HOLD = 16)
`endif
(
  input  logic               clk,
  input  logic               rst_n,
  rr_enc_arbiter8_if.slave   bus
);

  localparam int N    = 8;
  localparam int IDXW = $clog2(N);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [IDXW-1:0]   ptr_q, ptr_d;
  logic              gnt_valid_q, gnt_valid_d;
  logic [N-1:0]      gnt_onehot_q, gnt_onehot_d;
  logic [IDXW-1:0]   gnt_idx_q, gnt_idx_d;

  logic              pick_found;
  logic [IDXW-1:0]   pick_idx;
  logic [IDXW-1:0]   cand;
  logic              expired;
  logic              release_c;

  // Scan ptr, ptr+1, ... with natural 3-bit wrap; first set request wins.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 0; i < N; i++) begin
      cand = ptr_q + IDXW'(i);
      if (!pick_found && bus.req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CNTW = $clog2(MAX_HOLD) + 1;

  logic [CNTW-1:0] hold_cnt_q, hold_cnt_d;
  logic            timeout_q, timeout_d;

  assign expired = (state_q == ST_GRANT) && (hold_cnt_q == CNTW'(MAX_HOLD - 1));

  // Counter is zero in IDLE, so it is already clear on the first GRANT cycle.
  always_comb begin
    hold_cnt_d = '0;
    if (state_q == ST_GRANT && !release_c) begin
      hold_cnt_d = hold_cnt_q + CNTW'(1);
    end
  end

  // The pulse is attributed to the timer only when the holder did not release itself.
  always_comb begin
    timeout_d = expired && !bus.rel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign expired     = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  assign release_c = bus.rel || !bus.req[gnt_idx_q] || !bus.en || expired;

  // State register: all state and registered outputs share one async-reset process.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      gnt_valid_q  <= 1'b0;
      gnt_onehot_q <= '0;
      gnt_idx_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      gnt_valid_q  <= gnt_valid_d;
      gnt_onehot_q <= gnt_onehot_d;
      gnt_idx_q    <= gnt_idx_d;
    end
  end

  // Next state; the release edge always lands in IDLE, forcing one idle cycle.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.en && pick_found) begin
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (release_c) begin
          state_d = ST_IDLE;
          ptr_d   = gnt_idx_q + IDXW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Registered output values; index and one-hot are always derived from the same k.
  always_comb begin
    gnt_valid_d  = (state_d == ST_GRANT);
    gnt_idx_d    = '0;
    gnt_onehot_d = '0;
    if (state_q == ST_IDLE && state_d == ST_GRANT) begin
      gnt_idx_d = pick_idx;
    end else if (state_d == ST_GRANT) begin
      gnt_idx_d = gnt_idx_q;
    end
    if (gnt_valid_d) begin
      gnt_onehot_d = N'(1) << gnt_idx_d;
    end
  end

  assign bus.gnt_valid  = gnt_valid_q;
  assign bus.gnt_onehot = gnt_onehot_q;
  assign bus.gnt_idx    = gnt_idx_q;

endmodule

// File: tb/tb_rr_enc_arbiter8.sv
// Scoreboard bench for rr_enc_arbiter8: directed scenarios then random traffic, checked
// against a queue of expected outputs from a behavioural model (honours ARB_TIMEOUT_EN).
module tb_rr_enc_arbiter8;

`ifdef ARB_TIMEOUT_EN
  localparam int MAX_HOLD = 16;
`endif

  typedef struct packed {
    logic       v;
    logic [7:0] oh;
    logic [2:0] idx;
    logic       to;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rr_enc_arbiter8_if bus();

  rr_enc_arbiter8 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  exp_t exp_q[$];

  // Reference model state: who holds the grant, where the scan starts, hold age.
  bit m_hold;
  int m_k;
  int m_ptr;
  int m_cnt;
  bit m_to;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (fields v,onehot,idx,timeout)", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_hold = 1'b0;
    m_k    = 0;
    m_ptr  = 0;
    m_cnt  = 0;
    m_to   = 1'b0;
  endtask

  task automatic model_step(input logic e, input logic [7:0] r, input logic rl);
    bit   expired;
    bit   found;
    exp_t x;
    m_to    = 1'b0;
    expired = 1'b0;
    if (m_hold) begin
`ifdef ARB_TIMEOUT_EN
      expired = (m_cnt == MAX_HOLD - 1);
`endif
      if (rl || !r[m_k] || !e || expired) begin
        m_to   = expired && !rl;
        m_hold = 1'b0;
        m_ptr  = (m_k + 1) % 8;
      end else begin
        m_cnt++;
      end
    end else if (e && r != 8'h00) begin
      found = 1'b0;
      for (int i = 0; i < 8; i++) begin
        int j;
        j = (m_ptr + i) % 8;
        if (!found && r[j]) begin
          found = 1'b1;
          m_k   = j;
        end
      end
      m_hold = 1'b1;
      m_cnt  = 0;
    end
    x.v   = m_hold;
    x.oh  = m_hold ? (8'h01 << m_k) : 8'h00;
    x.idx = m_hold ? 3'(m_k) : 3'd0;
    x.to  = m_to;
    exp_q.push_back(x);
  endtask

  // One clock of stimulus: drive at the falling edge, predict at the rising edge.
  task automatic step(input logic e, input logic [7:0] r, input logic rl);
    @(negedge clk);
    bus.en  = e;
    bus.req = r;
    bus.rel = rl;
    @(posedge clk);
    model_step(e, r, rl);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear immediately.
  task automatic do_reset(input string name);
    @(negedge clk);
    #1;
    rst_n   = 1'b0;
    bus.en  = 1'b0;
    bus.req = 8'h00;
    bus.rel = 1'b0;
    #1;
    check(name, 32'({bus.gnt_valid, bus.gnt_onehot, bus.gnt_idx, bus.timeout}), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: every cycle with a pending prediction, compare the sampled outputs.
  initial begin
    exp_t e;
    exp_t a;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {bus.gnt_valid, bus.gnt_onehot, bus.gnt_idx, bus.timeout};
        check($sformatf("cycle%0d", cyc), 32'(a), 32'(e));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r;
    logic       e;
    logic       rl;

    rst_n   = 1'b0;
    bus.en  = 1'b0;
    bus.req = 8'h00;
    bus.rel = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_state", 32'({bus.gnt_valid, bus.gnt_onehot, bus.gnt_idx, bus.timeout}), 32'd0);
    rst_n = 1'b1;

    // Reset mid-grant of requester 5, then first grant from ptr 0.
    step(1'b1, 8'h20, 1'b0);
    step(1'b1, 8'h20, 1'b0);
    do_reset("reset_mid_grant");
    step(1'b1, 8'hFF, 1'b0);

    // Rotation with idle cycles between grants, including the 7->0 wrap.
    repeat (18) step(1'b1, 8'hFF, 1'b1);
    step(1'b1, 8'h00, 1'b0);
    step(1'b1, 8'h00, 1'b0);

    // Skip to 7 from ptr 3, then wrap to 1.
    step(1'b1, 8'h04, 1'b0);
    step(1'b1, 8'h04, 1'b1);
    step(1'b1, 8'h82, 1'b0);
    step(1'b1, 8'h82, 1'b1);
    step(1'b1, 8'h82, 1'b0);
    step(1'b1, 8'h82, 1'b1);

    // Enable gating: no grant while low, forced release when it drops in GRANT.
    step(1'b0, 8'h10, 1'b0);
    step(1'b0, 8'h10, 1'b0);
    step(1'b1, 8'h10, 1'b0);
    step(1'b1, 8'h10, 1'b0);
    step(1'b0, 8'h10, 1'b0);
    step(1'b0, 8'h10, 1'b0);

    // Request drop releases the holder (ptr 5 scans to 2, then ptr becomes 3).
    step(1'b1, 8'h04, 1'b0);
    step(1'b1, 8'h04, 1'b0);
    step(1'b1, 8'h00, 1'b0);
    step(1'b1, 8'h00, 1'b0);
    step(1'b1, 8'h08, 1'b0);
    step(1'b1, 8'h08, 1'b1);

    // Long hold: timer revoke and regrant when enabled, indefinite hold otherwise.
    repeat (100) step(1'b1, 8'h04, 1'b0);
    step(1'b1, 8'h04, 1'b1);

    // Random traffic with occasional mid-run reset.
    r = 8'hFF;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 3) == 0) r = 8'($urandom);
      if ($urandom_range(0, 15) == 0) r = 8'h00;
      e  = ($urandom_range(0, 9) != 0);
      rl = ($urandom_range(0, 5) == 0);
      step(e, r, rl);
      if (n == 700) do_reset("reset_random");
    end

    @(posedge clk);
    #2;
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
